// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator/logic unit: op codes and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd4;
  localparam logic [3:0] OP_CLA = 4'd5;
  localparam logic [3:0] OP_CMA = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;
  localparam logic [3:0] OP_CLE = 4'd8;
  localparam logic [3:0] OP_CME = 4'd9;
  localparam logic [3:0] OP_CIR = 4'd10;
  localparam logic [3:0] OP_CIL = 4'd11;

  // Codes from here upward are reserved and behave like NOP (done still pulses).
  localparam logic [3:0] OP_RSV_FIRST = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// WIDTH-bit adder with carry-in; shared by ADD, ADC and INC.
module acc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  // Sum is formed one bit wider so the carry-out falls out as the top bit.
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/acc_logic_unit.sv
// Registered accumulator (AC) and extend bit (E) with single-cycle ops and
// multi-cycle rotate-through-E under a valid/ready handshake.
module acc_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [3:0]       i_op,
  input  logic [CNT_W-1:0] i_amount,
  input  logic [WIDTH-1:0] i_dr,
  output logic [WIDTH-1:0] o_ac,
  output logic             o_e,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_done
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_dir;
  logic [WIDTH-1:0]   r_ac;
  logic               r_e;
  logic               r_done;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_dir_nxt;
  logic [WIDTH-1:0]   w_ac_nxt;
  logic               w_e_nxt;
  logic               w_done_nxt;

  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_rot_ac;
  logic               w_rot_e;

  // INC reuses the adder with b=1 and no carry-in; only ADC feeds E back in.
  assign w_add_b   = (i_op == OP_INC) ? WIDTH'(1) : i_dr;
  assign w_add_cin = (i_op == OP_ADC) & r_e;

  acc_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a     (r_ac),
    .i_b     (w_add_b),
    .i_cin   (w_add_cin),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // One-bit rotate of {E,AC}; r_dir=1 means left (CIL), 0 means right (CIR).
  assign w_rot_ac = r_dir ? {r_ac[WIDTH-2:0], r_e} : {r_e, r_ac[WIDTH-1:1]};
  assign w_rot_e  = r_dir ? r_ac[WIDTH-1] : r_ac[0];

  // Next-state and datapath decode: single-cycle ops resolve in IDLE, a
  // non-zero rotate parks in ROT and steps once per cycle until count runs out.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_ac_nxt    = r_ac;
    w_e_nxt     = r_e;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_op_valid) begin
          w_done_nxt = 1'b1;
          case (i_op)
            OP_AND: w_ac_nxt = r_ac & i_dr;
            OP_ADD, OP_ADC: begin
              w_ac_nxt = w_sum;
              w_e_nxt  = w_carry;
            end
            OP_LDA: w_ac_nxt = i_dr;
            OP_CLA: w_ac_nxt = '0;
            OP_CMA: w_ac_nxt = ~r_ac;
            OP_INC: w_ac_nxt = w_sum;
            OP_CLE: w_e_nxt  = 1'b0;
            OP_CME: w_e_nxt  = ~r_e;
            OP_CIR, OP_CIL: begin
              if (i_amount != '0) begin
                w_state_nxt = ROT;
                w_count_nxt = i_amount;
                w_dir_nxt   = (i_op == OP_CIL);
                w_done_nxt  = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      ROT: begin
        w_ac_nxt    = w_rot_ac;
        w_e_nxt     = w_rot_e;
        w_count_nxt = r_count - CNT_W'(1);
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any rotate without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_dir   <= 1'b0;
      r_ac    <= '0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_ac    <= w_ac_nxt;
      r_e     <= w_e_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_op_ready = (r_state == IDLE);
  assign o_ac       = r_ac;
  assign o_e        = r_e;
  assign o_done     = r_done;
  assign o_zero     = (r_ac == '0);
  assign o_neg      = r_ac[WIDTH-1];

endmodule

// File: tb/tb_acc_logic_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a behavioural model.
module tb_acc_logic_unit;

  localparam int W  = 8;
  localparam int CW = 3;

  localparam logic [3:0] NOP = 4'd0,  AND_ = 4'd1, ADD = 4'd2,  ADC = 4'd3;
  localparam logic [3:0] LDA = 4'd4,  CLA  = 4'd5, CMA = 4'd6,  INC = 4'd7;
  localparam logic [3:0] CLE = 4'd8,  CME  = 4'd9, CIR = 4'd10, CIL = 4'd11;

  logic          i_clk;
  logic          i_rst;
  logic          i_op_valid;
  logic          o_op_ready;
  logic [3:0]    i_op;
  logic [CW-1:0] i_amount;
  logic [W-1:0]  i_dr;
  logic [W-1:0]  o_ac;
  logic          o_e;
  logic          o_zero;
  logic          o_neg;
  logic          o_done;

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  acc_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_op_valid (i_op_valid),
    .o_op_ready (o_op_ready),
    .i_op       (i_op),
    .i_amount   (i_amount),
    .i_dr       (i_dr),
    .o_ac       (o_ac),
    .o_e        (o_e),
    .o_zero     (o_zero),
    .o_neg      (o_neg),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural model: {E,AC} treated as one W+1 bit value; a rotate of n
  // steps is a plain rotation of that value, recomputed from the start value.
  logic [W-1:0] m_ac;
  logic         m_e;
  logic         m_done;
  bit           m_busy;
  logic [W:0]   m_start;
  int           m_total;
  int           m_steps;
  bit           m_left;

  function automatic logic [W:0] rotThrough(logic [W:0] v, int n, bit left);
    logic [2*W+1:0] d;
    int r;
    r = left ? ((W + 1 - n) % (W + 1)) : n;
    d = {v, v} >> r;
    return d[W:0];
  endfunction

  // Model update on every rising edge from the same inputs the DUT sees.
  always @(posedge i_clk) begin
    int s;
    if (i_rst) begin
      m_ac = '0; m_e = 1'b0; m_done = 1'b0; m_busy = 0;
    end else if (m_busy) begin
      m_steps = m_steps + 1;
      {m_e, m_ac} = rotThrough(m_start, m_steps, m_left);
      if (m_steps == m_total) begin
        m_busy = 0; m_done = 1'b1;
      end else begin
        m_done = 1'b0;
      end
    end else if (i_op_valid) begin
      m_done = 1'b1;
      case (i_op)
        AND_: m_ac = m_ac & i_dr;
        ADD, ADC: begin
          s = int'(m_ac) + int'(i_dr) + ((i_op == ADC) ? int'(m_e) : 0);
          m_ac = s[W-1:0];
          m_e  = s[W];
        end
        LDA: m_ac = i_dr;
        CLA: m_ac = '0;
        CMA: m_ac = ~m_ac;
        INC: m_ac = m_ac + 1'b1;
        CLE: m_e = 1'b0;
        CME: m_e = ~m_e;
        CIR, CIL: begin
          if (i_amount != 0) begin
            m_busy  = 1;
            m_start = {m_e, m_ac};
            m_total = int'(i_amount);
            m_steps = 0;
            m_left  = (i_op == CIL);
            m_done  = 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge i_clk) begin
    if (checkEn) begin
      checkOutput("cmp_ac",    32'(o_ac),       32'(m_ac));
      checkOutput("cmp_e",     32'(o_e),        32'(m_e));
      checkOutput("cmp_zero",  32'(o_zero),     32'(m_ac == '0));
      checkOutput("cmp_neg",   32'(o_neg),      32'(m_ac[W-1]));
      checkOutput("cmp_ready", 32'(o_op_ready), 32'(!m_busy));
      checkOutput("cmp_done",  32'(o_done),     32'(m_done));
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [CW-1:0] amt, input logic [W-1:0] d);
    @(negedge i_clk);
    i_op_valid = v;
    i_op       = op;
    i_amount   = amt;
    i_dr       = d;
  endtask

  task automatic issue(input logic [3:0] op, input logic [CW-1:0] amt,
                       input logic [W-1:0] d);
    applyStimulus(1'b1, op, amt, d);
    applyStimulus(1'b0, NOP, '0, '0);
  endtask

  task automatic waitDone(input int limit);
    int n;
    n = 0;
    while (!o_done && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_done) checkOutput("done_timeout", 32'(o_done), 32'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_op_valid = 1'b0; i_op = NOP; i_amount = '0; i_dr = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    checkEn = 1;

    $display("[TB] reset state");
    checkOutput("rst_ac",    32'(o_ac), 32'h00);
    checkOutput("rst_e",     32'(o_e), 32'd0);
    checkOutput("rst_zero",  32'(o_zero), 32'd1);
    checkOutput("rst_ready", 32'(o_op_ready), 32'd1);
    checkOutput("rst_done",  32'(o_done), 32'd0);

    issue(LDA, 0, 8'hF0);
    checkOutput("lda_ac",   32'(o_ac), 32'hF0);
    checkOutput("lda_neg",  32'(o_neg), 32'd1);
    checkOutput("lda_done", 32'(o_done), 32'd1);

    $display("[TB] add / adc");
    issue(LDA, 0, 8'hFF);
    issue(ADD, 0, 8'h01);
    checkOutput("add_ac",   32'(o_ac), 32'h00);
    checkOutput("add_e",    32'(o_e), 32'd1);
    checkOutput("add_zero", 32'(o_zero), 32'd1);
    issue(ADC, 0, 8'h00);
    checkOutput("adc_ac", 32'(o_ac), 32'h01);
    checkOutput("adc_e",  32'(o_e), 32'd0);

    $display("[TB] rotates");
    issue(LDA, 0, 8'h81);
    issue(CLE, 0, 8'h00);
    issue(CIR, 3'd1, 8'h00);
    checkOutput("cir1_busy_ready", 32'(o_op_ready), 32'd0);
    checkOutput("cir1_busy_ac",    32'(o_ac), 32'h81);
    @(negedge i_clk);
    checkOutput("cir1_ac",    32'(o_ac), 32'h40);
    checkOutput("cir1_e",     32'(o_e), 32'd1);
    checkOutput("cir1_done",  32'(o_done), 32'd1);
    checkOutput("cir1_ready", 32'(o_op_ready), 32'd1);
    issue(LDA, 0, 8'h81);
    issue(CIL, 3'd3, 8'h00);
    waitDone(20);
    checkOutput("cil3_ac", 32'(o_ac), 32'h0E);
    checkOutput("cil3_e",  32'(o_e), 32'd0);

    $display("[TB] back-to-back stream");
    applyStimulus(1'b1, CLA, 0, 0);
    applyStimulus(1'b1, CME, 0, 0);
    checkOutput("s_cla_ac", 32'(o_ac), 32'h00);
    checkOutput("s_cla_done", 32'(o_done), 32'd1);
    applyStimulus(1'b1, CMA, 0, 0);
    checkOutput("s_cme_e", 32'(o_e), 32'd1);
    checkOutput("s_cme_done", 32'(o_done), 32'd1);
    applyStimulus(1'b1, INC, 0, 0);
    checkOutput("s_cma_ac", 32'(o_ac), 32'hFF);
    checkOutput("s_cma_done", 32'(o_done), 32'd1);
    applyStimulus(1'b0, NOP, 0, 0);
    checkOutput("s_inc_ac", 32'(o_ac), 32'h00);
    checkOutput("s_inc_e",  32'(o_e), 32'd1);
    checkOutput("s_inc_done", 32'(o_done), 32'd1);
    @(negedge i_clk);
    checkOutput("s_idle_done", 32'(o_done), 32'd0);

    $display("[TB] reset during rotate");
    issue(LDA, 0, 8'hA5);
    issue(CLE, 0, 8'h00);
    issue(CIL, 3'd7, 8'h00);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("abort_ac",    32'(o_ac), 32'h00);
    checkOutput("abort_e",     32'(o_e), 32'd0);
    checkOutput("abort_done",  32'(o_done), 32'd0);
    checkOutput("abort_ready", 32'(o_op_ready), 32'd1);

    $display("[TB] zero-amount rotate and reserved op");
    issue(LDA, 0, 8'h3C);
    issue(CIR, 3'd0, 8'h00);
    checkOutput("amt0_ac",   32'(o_ac), 32'h3C);
    checkOutput("amt0_done", 32'(o_done), 32'd1);
    @(negedge i_clk);
    checkOutput("amt0_single", 32'(o_done), 32'd0);
    issue(4'd13, 0, 8'hFF);
    checkOutput("rsv_ac",   32'(o_ac), 32'h3C);
    checkOutput("rsv_e",    32'(o_e), 32'd0);
    checkOutput("rsv_done", 32'(o_done), 32'd1);
    @(negedge i_clk);
    checkOutput("rsv_single", 32'(o_done), 32'd0);

    $display("[TB] request held during rotate");
    applyStimulus(1'b1, CIR, 3'd2, 8'h00);
    applyStimulus(1'b1, LDA, 0, 8'h55);
    waitDone(20);
    checkOutput("hold_rot_ac", 32'(o_ac), 32'h0F);
    @(negedge i_clk);
    i_op_valid = 1'b0;
    checkOutput("hold_lda_ac",   32'(o_ac), 32'h55);
    checkOutput("hold_lda_done", 32'(o_done), 32'd1);

    $display("[TB] randomized run");
    for (int i = 0; i < 600; i++) begin
      @(negedge i_clk);
      i_rst      = ($urandom_range(0, 63) == 0);
      i_op_valid = ($urandom_range(0, 3) != 0);
      i_op       = 4'($urandom_range(0, 15));
      i_amount   = CW'($urandom_range(0, 7));
      i_dr       = W'($urandom);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_op_valid = 1'b0;
    repeat (10) @(negedge i_clk);

    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
